// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter (optional parity bit), LSB first.
// Bytes enter a DEPTH-entry FIFO over a valid/ready handshake. A five-state FSM
// serialises them on a registered tx_o. Back-to-back frames have no idle gap.
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUDRATE   = 115200,
    parameter int unsigned DEPTH      = 16,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [7:0]               data_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic                     tx_o,
    output logic                     busy_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned DIV = CLK_FREQ / BAUDRATE;
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BaudMax = BW'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("uart_tx_fifo: CLK_FREQ/BAUDRATE must be at least 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("uart_tx_fifo: DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push, pop;
    logic [7:0]    fifo_rd;

    state_e        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic          tx_q, tx_d;
    logic          baud_last;

    assign ready_o   = (count_q != CW'(DEPTH));
    assign push      = valid_i && ready_o;
    assign fifo_rd   = mem_q[rd_ptr_q];
    assign baud_last = (baud_q == BaudMax);

    assign tx_o    = tx_q;
    assign count_o = count_q;
    assign busy_o  = (state_q != StIdle) || (count_q != '0);

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of 2).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Transmitter state, counters, shifter and line register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

    // Next-state logic; a pop from IDLE or the last STOP cycle starts a new frame.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_last ? '0 : baud_q + BW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        pop      = 1'b0;

        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                tx_d   = 1'b1;
                pop    = (count_q != '0);
            end
            StStart: begin
                if (baud_last) begin
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (baud_last) begin
                    if (bit_q == 3'd7) begin
                        if (PARITY_EN) begin
                            tx_d    = parity_q;
                            state_d = StParity;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = StStop;
                        end
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (baud_last) begin
                    tx_d    = 1'b1;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (baud_last) begin
                    tx_d    = 1'b1;
                    state_d = StIdle;
                    pop     = (count_q != '0);
                end
            end
            default: begin
                baud_d  = '0;
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase

        if (pop) begin
            shift_d  = fifo_rd;
            parity_d = (^fifo_rd) ^ PARITY_ODD;
            tx_d     = 1'b0;
            baud_d   = '0;
            state_d  = StStart;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 8 clocks per bit: a frame-vector table plus
// hand-written sequences for FIFO-full streaming, mid-frame reset and push-on-pop.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int unsigned ClkFreq = 800;
    localparam int unsigned Baud    = 100;
    localparam int          Div     = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic       valid0, valid1, valid2;
    logic       ready0, ready1, ready2;
    logic       tx0, tx1, tx2;
    logic       busy0, busy1, busy2;
    logic [4:0] count0, count1, count2;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_bytes [20];

    typedef struct {
        int          inst;
        logic [7:0]  data;
        int          nbits;
        logic [10:0] frame;  // line bits, bit 0 = start bit
    } vec_t;
    vec_t vecs [8];

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(ClkFreq), .BAUDRATE(Baud), .DEPTH(16),
                   .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .data_i(data), .valid_i(valid0),
        .ready_o(ready0), .tx_o(tx0), .busy_o(busy0), .count_o(count0)
    );

    uart_tx_fifo #(.CLK_FREQ(ClkFreq), .BAUDRATE(Baud), .DEPTH(16),
                   .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_par_even (
        .clk_i(clk), .rst_ni(rst_n), .data_i(data), .valid_i(valid1),
        .ready_o(ready1), .tx_o(tx1), .busy_o(busy1), .count_o(count1)
    );

    uart_tx_fifo #(.CLK_FREQ(ClkFreq), .BAUDRATE(Baud), .DEPTH(16),
                   .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_par_odd (
        .clk_i(clk), .rst_ni(rst_n), .data_i(data), .valid_i(valid2),
        .ready_o(ready2), .tx_o(tx2), .busy_o(busy2), .count_o(count2)
    );

    function automatic int tx_of(input int i);
        case (i)
            0:       return int'(tx0);
            1:       return int'(tx1);
            default: return int'(tx2);
        endcase
    endfunction

    function automatic int busy_of(input int i);
        case (i)
            0:       return int'(busy0);
            1:       return int'(busy1);
            default: return int'(busy2);
        endcase
    endfunction

    function automatic int count_of(input int i);
        case (i)
            0:       return int'(count0);
            1:       return int'(count1);
            default: return int'(count2);
        endcase
    endfunction

    task automatic set_valid(input int i, input logic v);
        case (i)
            0:       valid0 = v;
            1:       valid1 = v;
            default: valid2 = v;
        endcase
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Compare consecutive contiguous 8N1 frames on u_dut against exp_bytes;
    // the first sample is taken in the current cycle (start bit expected).
    task automatic check_frames(input string name, input int n);
        for (int f = 0; f < n; f++) begin
            int   bad_cyc;
            bad_cyc = 0;
            for (int c = 0; c < 10 * Div; c++) begin
                int   idx;
                logic expb;
                idx = c / Div;
                if (idx == 0)      expb = 1'b0;
                else if (idx == 9) expb = 1'b1;
                else               expb = exp_bytes[f][idx-1];
                if (tx0 !== expb) bad_cyc++;
                @(negedge clk);
            end
            check($sformatf("%s_frame%0d_badcycles", name, f), bad_cyc, 0);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   idx, guard, w, ready_bad, idle_bad;
        logic r, saw_full;

        vecs[0] = '{0, 8'h56, 10, 11'b0_1_01010110_0};
        vecs[1] = '{0, 8'hA5, 10, 11'b0_1_10100101_0};
        vecs[2] = '{0, 8'h00, 10, 11'b0_1_00000000_0};
        vecs[3] = '{0, 8'hFF, 10, 11'b0_1_11111111_0};
        vecs[4] = '{1, 8'h07, 11, 11'b1_1_00000111_0};
        vecs[5] = '{2, 8'h07, 11, 11'b1_0_00000111_0};
        vecs[6] = '{1, 8'h80, 11, 11'b1_1_10000000_0};
        vecs[7] = '{2, 8'h03, 11, 11'b1_1_00000011_0};

        // Reset state
        rst_n = 1'b0; data = 8'h00; valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", int'(tx0), 1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_tx", int'(tx0), 1);
        check("idle_ready", int'(ready0), 1);
        check("idle_busy", int'(busy0), 0);
        check("idle_count", int'(count0), 0);
        check("idle_tx_par", int'(tx1), 1);

        // Single frames, one byte into an empty FIFO each
        for (int v = 0; v < 8; v++) begin
            int inst;
            inst = vecs[v].inst;
            data = vecs[v].data;
            set_valid(inst, 1'b1);
            @(negedge clk);
            set_valid(inst, 1'b0);
            check($sformatf("v%0d_count_after_push", v), count_of(inst), 1);
            check($sformatf("v%0d_tx_before_start", v), tx_of(inst), 1);
            @(negedge clk);
            check($sformatf("v%0d_count_after_pop", v), count_of(inst), 0);
            for (int b = 0; b < vecs[v].nbits; b++) begin
                int bad_cyc;
                bad_cyc = 0;
                for (int c = 0; c < Div; c++) begin
                    if (tx_of(inst) !== int'(vecs[v].frame[b])) bad_cyc++;
                    if (b == vecs[v].nbits - 1 && c == Div - 1)
                        check($sformatf("v%0d_busy_last_cycle", v), busy_of(inst), 1);
                    @(negedge clk);
                end
                check($sformatf("v%0d_bit%0d_badcycles", v, b), bad_cyc, 0);
            end
            check($sformatf("v%0d_busy_after", v), busy_of(inst), 0);
            check($sformatf("v%0d_tx_after", v), tx_of(inst), 1);
        end

        // 20 bytes streamed with valid held; FIFO must fill and frames stay contiguous
        for (int k = 0; k < 20; k++) exp_bytes[k] = 8'(k);
        idx = 0; guard = 0; w = 0; ready_bad = 0; saw_full = 1'b0;
        fork
            begin
                while (idx < 20 && guard < 5000) begin
                    data   = 8'(idx);
                    valid0 = 1'b1;
                    r      = ready0;
                    if (ready0 !== (count0 != 5'd16)) ready_bad++;
                    if (count0 == 5'd16 && ready0 == 1'b0) saw_full = 1'b1;
                    @(negedge clk);
                    if (r) idx++;
                    guard++;
                end
                valid0 = 1'b0;
            end
            begin
                while (tx0 !== 1'b0 && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                if (tx0 !== 1'b0) check("t3_first_start", int'(tx0), 0);
                else check_frames("t3", 20);
            end
        join
        check("t3_pushed", idx, 20);
        check("t3_saw_full", int'(saw_full), 1);
        check("t3_ready_vs_count_bad", ready_bad, 0);
        check("t3_busy_end", int'(busy0), 0);
        check("t3_count_end", int'(count0), 0);

        // Reset during data bit 3 of the first of three queued frames
        data = 8'hF7; valid0 = 1'b1;
        @(negedge clk);
        data = 8'h11;
        @(negedge clk);
        data = 8'h22;
        @(negedge clk);
        valid0 = 1'b0;
        repeat (4 * Div + 2) @(negedge clk);
        check("t5_bit3_low", int'(tx0), 0);
        check("t5_count_mid", int'(count0), 2);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_tx", int'(tx0), 1);
        check("t5_rst_count", int'(count0), 0);
        check("t5_rst_busy", int'(busy0), 0);
        check("t5_rst_ready", int'(ready0), 1);
        @(negedge clk);
        rst_n = 1'b1;
        idle_bad = 0;
        for (int c = 0; c < 30 * Div; c++) begin
            if (tx0 !== 1'b1 || busy0 !== 1'b0 || count0 !== 5'd0) idle_bad++;
            @(negedge clk);
        end
        check("t5_idle_after_rst_badcycles", idle_bad, 0);

        // Push on the same edge as the STOP-completion pop with one byte queued
        data = 8'h3C; valid0 = 1'b1;
        @(negedge clk);
        data = 8'hC3;
        @(negedge clk);
        valid0 = 1'b0;
        check("t6_count_during_a", int'(count0), 1);
        repeat (10 * Div - 1) @(negedge clk);
        check("t6_stop_bit", int'(tx0), 1);
        check("t6_count_before", int'(count0), 1);
        data = 8'h5A; valid0 = 1'b1;
        @(negedge clk);
        valid0 = 1'b0;
        check("t6_count_push_pop", int'(count0), 1);
        exp_bytes[0] = 8'hC3;
        exp_bytes[1] = 8'h5A;
        check_frames("t6", 2);
        check("t6_busy_end", int'(busy0), 0);
        check("t6_tx_end", int'(tx0), 1);
        check("t6_count_end", int'(count0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
